// File: rtl/usb_tx_serializer.sv
// Full-speed USB transmit serializer: pops packet bytes from the byte FIFO,
// frames them with SYNC/EOP, bit-stuffs, NRZI-encodes and drives D+/D-.
module usb_tx_serializer #(
  parameter int CLKS_PER_BIT    = 4,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int LEN_W           = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_start,
  input  logic [LEN_W-1:0]           pkt_len,
  input  logic                       fifo_empty,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_r_data,
  output logic                       fifo_rd_en,
  output logic                       tx_dp,
  output logic                       tx_dn,
  output logic                       tx_oe,
  output logic                       busy,
  output logic                       done,
  output logic                       err_underrun
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_EOP_SE0 = 3'd3;
  localparam logic [2:0] S_EOP_J   = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [2:0]                 bitcnt_q, bitcnt_d;
  logic [2:0]                 ones_q, ones_d;
  logic [FIFO_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [FIFO_DATA_WIDTH-1:0] hold_q, hold_d;
  logic [LEN_W-1:0]           remaining_q, remaining_d;
  logic                       underrun_q, underrun_d;
  logic                       fetch_q, fetch_d;
  logic                       cap_q, cap_d;
  logic                       dp_q, dp_d;
  logic                       dn_q, dn_d;
  logic                       oe_q, oe_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic rd_en_s, boundary_s, emit_s, bit_s, load_s, eop_s;

  // Next-state, line encoding and FIFO pop decisions.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bitcnt_d    = bitcnt_q;
    ones_d      = ones_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    underrun_d  = underrun_q;
    fetch_d     = 1'b0;
    cap_d       = 1'b0;
    dp_d        = dp_q;
    dn_d        = dn_q;
    oe_d        = oe_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_en_s     = 1'b0;
    emit_s      = 1'b0;
    bit_s       = 1'b0;
    load_s      = 1'b0;
    eop_s       = 1'b0;
    boundary_s  = (baud_q == BAUD_LAST);

    if (cap_q) begin
      hold_d = fifo_r_data;
    end else begin
      hold_d = hold_q;
    end

    if (state_q == S_IDLE) begin
      baud_d = '0;
    end else begin
      baud_d = boundary_s ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start && (pkt_len != '0)) begin
          if (fifo_empty) begin
            err_d = 1'b1;
          end else begin
            // First SYNC bit is a 0, so the line leaves J for K right away.
            rd_en_s     = 1'b1;
            cap_d       = 1'b1;
            remaining_d = pkt_len;
            underrun_d  = 1'b0;
            bitcnt_d    = 3'd0;
            ones_d      = 3'd0;
            oe_d        = 1'b1;
            dp_d        = 1'b0;
            dn_d        = 1'b1;
            state_d     = S_SYNC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SYNC: begin
        if (boundary_s) begin
          if (bitcnt_q != 3'd7) begin
            bitcnt_d = bitcnt_q + 3'd1;
            emit_s   = 1'b1;
            bit_s    = (bitcnt_q == 3'd6);
          end else begin
            load_s = 1'b1;
          end
        end else begin
          state_d = S_SYNC;
        end
      end
      S_DATA: begin
        // Prefetch the next byte during the first clk of each byte.
        if (fetch_q && (remaining_q != '0)) begin
          if (!fifo_empty) begin
            rd_en_s = 1'b1;
            cap_d   = 1'b1;
          end else begin
            underrun_d = 1'b1;
          end
        end else begin
          underrun_d = underrun_q;
        end
        if (boundary_s) begin
          if (ones_q == 3'd6) begin
            emit_s = 1'b1;
            bit_s  = 1'b0;
          end else if (bitcnt_q != 3'd7) begin
            bitcnt_d = bitcnt_q + 3'd1;
            shift_d  = shift_q >> 1;
            emit_s   = 1'b1;
            bit_s    = shift_q[1];
          end else if (underrun_q) begin
            eop_s = 1'b1;
            err_d = 1'b1;
          end else if (remaining_q == '0) begin
            eop_s = 1'b1;
          end else begin
            load_s = 1'b1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_EOP_SE0: begin
        if (boundary_s) begin
          if (bitcnt_q == 3'd0) begin
            bitcnt_d = 3'd1;
          end else begin
            state_d = S_EOP_J;
            dp_d    = 1'b1;
            dn_d    = 1'b0;
          end
        end else begin
          state_d = S_EOP_SE0;
        end
      end
      S_EOP_J: begin
        if (boundary_s) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_EOP_J;
        end
      end
      default: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
        dp_d    = 1'b1;
        dn_d    = 1'b0;
      end
    endcase

    if (load_s) begin
      state_d     = S_DATA;
      shift_d     = hold_q;
      bitcnt_d    = 3'd0;
      remaining_d = remaining_q - LEN_W'(1);
      fetch_d     = 1'b1;
      emit_s      = 1'b1;
      bit_s       = hold_q[0];
    end else begin
      fetch_d = fetch_d;
    end

    if (eop_s) begin
      state_d  = S_EOP_SE0;
      bitcnt_d = 3'd0;
      dp_d     = 1'b0;
      dn_d     = 1'b0;
    end else begin
      state_d = state_d;
    end

    // NRZI: a 0 toggles J/K, a 1 holds the line and extends the ones run.
    if (emit_s) begin
      if (bit_s) begin
        ones_d = ones_q + 3'd1;
      end else begin
        ones_d = 3'd0;
        dp_d   = ~dp_q;
        dn_d   = ~dn_q;
      end
    end else begin
      ones_d = ones_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bitcnt_q    <= 3'd0;
      ones_q      <= 3'd0;
      shift_q     <= '0;
      hold_q      <= '0;
      remaining_q <= '0;
      underrun_q  <= 1'b0;
      fetch_q     <= 1'b0;
      cap_q       <= 1'b0;
      dp_q        <= 1'b1;
      dn_q        <= 1'b0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bitcnt_q    <= bitcnt_d;
      ones_q      <= ones_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      remaining_q <= remaining_d;
      underrun_q  <= underrun_d;
      fetch_q     <= fetch_d;
      cap_q       <= cap_d;
      dp_q        <= dp_d;
      dn_q        <= dn_d;
      oe_q        <= oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign fifo_rd_en   = rd_en_s;
  assign tx_dp        = dp_q;
  assign tx_dn        = dn_q;
  assign tx_oe        = oe_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: a byte-FIFO model feeds the DUT and
// a bit-level reference (SYNC, stuffing, NRZI, EOP) predicts the D+/D- stream.
module tb_usb_tx_serializer;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [10:0] pkt_len = 11'd0;
  logic        fifo_empty;
  logic [7:0]  fifo_r_data = 8'd0;
  logic        fifo_rd_en, tx_dp, tx_dn, tx_oe, busy, done, err_underrun;

  usb_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DATA_WIDTH(8), .LEN_W(11)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .pkt_len(pkt_len),
    .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data), .fifo_rd_en(fifo_rd_en),
    .tx_dp(tx_dp), .tx_dn(tx_dn), .tx_oe(tx_oe), .busy(busy), .done(done),
    .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  // FIFO model with registered read data; rd_cnt counts every pop strobe.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_ptr != wr_ptr) begin
        fifo_r_data <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  int oe_cycles, done_cnt, err_cnt, pops;
  bit timed_out;

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  // Reference: line levels per bit time ({dp,dn}: J=10, K=01, SE0=00).
  task automatic build_expected(input logic [7:0] bq[$]);
    logic [1:0] level;
    int ones;
    level = 2'b10;
    ones  = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (i != 7) level = (level == 2'b10) ? 2'b01 : 2'b10;
      exp_q.push_back(level);
    end
    ones = 1;
    foreach (bq[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (bq[k][b]) begin
          ones++;
        end else begin
          ones  = 0;
          level = (level == 2'b10) ? 2'b01 : 2'b10;
        end
        exp_q.push_back(level);
        if (ones == 6) begin
          ones  = 0;
          level = (level == 2'b10) ? 2'b01 : 2'b10;
          exp_q.push_back(level);
        end
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  function automatic int line_mismatch();
    for (int i = 0; i < obs_q.size(); i++) begin
      if (i / CPB >= exp_q.size()) return i;
      if (obs_q[i] !== exp_q[i / CPB]) return i;
    end
    return -1;
  endfunction

  // Starts a packet of len bytes and records the line until done (bounded).
  task automatic drive_packet(input int len, input int extra_start_at);
    logic [7:0] bq[$];
    int avail, n, p0, post;
    avail = wr_ptr - rd_ptr;
    n = (len < avail) ? len : avail;
    for (int i = 0; i < n; i++) bq.push_back(mem[rd_ptr + i]);
    build_expected(bq);
    obs_q.delete();
    oe_cycles = 0; done_cnt = 0; err_cnt = 0; post = 0; timed_out = 1'b1;
    p0 = rd_cnt;
    @(negedge clk);
    tx_start = 1'b1;
    pkt_len  = 11'(len);
    @(negedge clk);
    tx_start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (tx_oe) begin
        obs_q.push_back({tx_dp, tx_dn});
        oe_cycles++;
      end
      if (done) done_cnt++;
      if (err_underrun) err_cnt++;
      if (done_cnt > 0) post++;
      if (post > 4) begin
        timed_out = 1'b0;
        break;
      end
      if (c == extra_start_at) begin
        tx_start = 1'b1;
        pkt_len  = 11'd5;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
    pops = rd_cnt - p0;
  endtask

  task automatic check_packet(input string nm, input int exp_oe, input int exp_err, input int exp_pops);
    int mm;
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL %s timeout: done not seen within budget", nm);
    end
    checks++;
    if (oe_cycles !== exp_oe) begin
      failures++;
      $display("FAIL %s oe_cycles: got %0d want %0d", nm, oe_cycles, exp_oe);
    end
    mm = line_mismatch();
    checks++;
    if (mm !== -1) begin
      failures++;
      $display("FAIL %s line: first bad cycle %0d got %b (expected bits %0d)", nm, mm, obs_q[mm], exp_q.size());
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d want 1", nm, done_cnt);
    end
    checks++;
    if (err_cnt !== exp_err) begin
      failures++;
      $display("FAIL %s err_pulses: got %0d want %0d", nm, err_cnt, exp_err);
    end
    checks++;
    if (pops !== exp_pops) begin
      failures++;
      $display("FAIL %s rd_en_pulses: got %0d want %0d", nm, pops, exp_pops);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_dp, tx_dn, tx_oe, busy, done, err_underrun, fifo_rd_en} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_state: got %b want 1000000",
               {tx_dp, tx_dn, tx_oe, busy, done, err_underrun, fifo_rd_en});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_dp, tx_dn, tx_oe, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL post_reset_idle: got %b want 1000", {tx_dp, tx_dn, tx_oe, busy});
    end
  endtask

  task automatic test_zero_len();
    int p0, e, b;
    push(8'h00);
    p0 = rd_cnt; e = 0; b = 0;
    tx_start = 1'b1;
    pkt_len  = 11'd0;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4) begin
      if (err_underrun) e++;
      if (busy || tx_oe) b++;
      @(negedge clk);
    end
    checks++;
    if ((rd_cnt - p0) !== 0 || e !== 0 || b !== 0) begin
      failures++;
      $display("FAIL zero_len: pops %0d err %0d busy %0d want all 0", rd_cnt - p0, e, b);
    end
  endtask

  task automatic test_sync_zero();
    drive_packet(1, -1);
    check_packet("byte00", 76, 0, 1);
  endtask

  task automatic test_stuff_ff();
    push(8'hFF);
    drive_packet(1, -1);
    check_packet("byteFF", 80, 0, 1);
  endtask

  task automatic test_refuse();
    int p0, e, b;
    p0 = rd_cnt; e = 0; b = 0;
    tx_start = 1'b1;
    pkt_len  = 11'd3;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5) begin
      if (err_underrun) e++;
      if (busy || tx_oe) b++;
      @(negedge clk);
    end
    checks++;
    if (e !== 1) begin
      failures++;
      $display("FAIL refuse_err: got %0d pulses want 1", e);
    end
    checks++;
    if (b !== 0 || (rd_cnt - p0) !== 0) begin
      failures++;
      $display("FAIL refuse_idle: busy/oe cycles %0d pops %0d want 0 0", b, rd_cnt - p0);
    end
  endtask

  task automatic test_underrun();
    push(8'hA5);
    drive_packet(3, -1);
    check_packet("underrun", 19 * CPB, 1, 1);
  endtask

  task automatic test_reset_mid();
    int len;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    @(negedge clk);
    tx_start = 1'b1;
    pkt_len  = 11'd4;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (45) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy_before: got %b want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx_dp, tx_dn, tx_oe, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_mid_abort: got %b want 1000", {tx_dp, tx_dn, tx_oe, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    push(8'($urandom));
    push(8'hFF);
    len = wr_ptr - rd_ptr;
    drive_packet(len, -1);
    check_packet("after_reset", exp_q.size() * CPB, 0, len);
  endtask

  task automatic test_back_to_back();
    push(8'hC3);
    push(8'h3C);
    drive_packet(2, 60);
    check_packet("back_to_back", (8 + 16 + 3) * CPB, 0, 2);
  endtask

  task automatic test_random();
    int len;
    for (int p = 0; p < 5; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) push(8'hFF);
        else push(8'($urandom));
      end
      drive_packet(len, -1);
      check_packet("random", exp_q.size() * CPB, 0, len);
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_sync_zero();
    test_stuff_ff();
    test_refuse();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
- Transmit-side consumer of the hub's byte FIFO: pops packet bytes (PID first), frames them with SYNC and EOP, applies bit stuffing and NRZI, and drives the full-speed D+/D- pair.
- Sits directly downstream of the byte FIFO's read port (fifo_rd_en / fifo_r_data / fifo_empty) and upstream of the USB transceiver pads.

Parameters:
- CLKS_PER_BIT, 4, system clocks per USB bit time (48 MHz clk / 12 Mb/s); minimum 3.
- FIFO_DATA_WIDTH, 8, FIFO byte width; fixed at 8 for USB.
- LEN_W, 11, width of pkt_len; max packet 2^LEN_W-1 bytes.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tx_start  input  1  one-clk request to send a packet; honoured only in IDLE.
- pkt_len  input  LEN_W  byte count including PID; sampled with tx_start.
- fifo_empty  input  1  FIFO empty flag.
- fifo_r_data  input  8  FIFO read data; registered, valid the clk after fifo_rd_en.
- fifo_rd_en  output  1  one-clk pop strobe to FIFO.
- tx_dp  output  1  D+ drive value.
- tx_dn  output  1  D- drive value.
- tx_oe  output  1  pad output enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-clk pulse at packet end (normal or underrun).
- err_underrun  output  1  one-clk pulse: packet aborted, or start refused.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (rst). On rst: state IDLE, tx_dp=1, tx_dn=0 (J), tx_oe=0, fifo_rd_en=0, busy=0, done=0, err_underrun=0; all counters and shift/holding registers 0. Reset mid-packet aborts immediately, with no EOP.
- Line states: J=(dp1,dn0), K=(dp0,dn1), SE0=(0,0). Idle line is J.
- Bit timing: baud counter 0..CLKS_PER_BIT-1. Line outputs change only when the counter wraps (bit boundary), except at start.
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
- IDLE:
  - tx_start with pkt_len==0 is ignored.
  - tx_start with fifo_empty=1 is refused: err_underrun pulse, stay IDLE.
  - Otherwise: latch remaining=pkt_len, pulse fifo_rd_en the same clk, capture fifo_r_data into the holding register the following clk, set tx_oe=1, enter SYNC. The first SYNC bit appears on the line the next clk.
- tx_start outside IDLE is ignored.
- SYNC: 8 bit times, pattern 0x80 LSB-first, NRZI-encoded from J, giving KJKJKJKK. No stuffing is applied inside SYNC. The ones counter leaves SYNC at 1.
- NRZI: data bit 0 toggles J/K; data bit 1 holds the current state.
- DATA:
  - At each byte boundary, load the shift register from the holding register, send LSB first, and decrement remaining.
  - During the first clk of a byte's first bit time, if remaining after decrement > 0: if fifo_empty=0, pulse fifo_rd_en and capture fifo_r_data one clk later; else set underrun_pending.
- Bit stuffing:
  - The ones counter increments on each transmitted 1 and clears on any 0, including stuffed 0s.
  - When it reaches 6, the next bit time is a stuffed 0 and the shift register does not advance.
  - Stuffing also applies after the last data bit before EOP.
- End of DATA:
  - After the last bit (and any pending stuff bit) of the final byte, go to EOP_SE0.
  - If underrun_pending at a byte boundary, go to EOP_SE0 instead of loading, and pulse err_underrun.
- EOP_SE0: 2 bit times of SE0. Then EOP_J: 1 bit time of J.
- Return to IDLE: at the end of EOP_J, tx_oe=0, pulse done, return to IDLE. A new tx_start is accepted the next clk.
- Total bit times = 8 + 8*pkt_len + stuffed bits + 3.

Test Plan:
- CLKS_PER_BIT=4, FIFO holds {0x00}, tx_start pkt_len=1 -> line KJKJKJKK JKJKJKJK, then SE0 SE0 J; tx_oe high for 76 clks; one fifo_rd_en; done pulses once; err_underrun stays 0.
- FIFO {0xFF}, pkt_len=1 -> after SYNC: K K K K K, J (stuffed), J J J, then EOP; 20 bit times = 80 clks tx_oe.
- fifo_empty=1 at tx_start -> err_underrun one clk, busy stays 0, tx_oe stays 0, no fifo_rd_en.
- FIFO {0xA5}, pkt_len=3 -> 0xA5 sent; empty detected at prefetch; EOP follows byte 1; err_underrun and done each pulse once.
- rst asserted mid-DATA -> same clk: tx_oe=0, dp/dn=J, busy=0; next tx_start after release sends a correct full packet.
- FIFO {0xC3, 0x3C}, pkt_len=2, second tx_start issued while busy -> ignored; exactly 2 fifo_rd_en pulses; byte order preserved on the line.
